// File: rtl/fp_addsub_sequencer_if.sv
// Handshake bundle between FPU issue, the add/sub sequencer and writeback.
// Operand/request side plus result side with status flags.
interface fp_addsub_sequencer_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] z;
  logic         overflow;
  logic         underflow;
  logic         busy;

  modport master (
    output in_valid, op_sub, x, y, out_ready,
    input  in_ready, out_valid, z, overflow, underflow, busy
  );

  modport slave (
    input  in_valid, op_sub, x, y, out_ready,
    output in_ready, out_valid, z, overflow, underflow, busy
  );
endinterface

// File: rtl/fp_addsub_sequencer.sv
// Multi-cycle single-precision add/subtract sequencer:
// swap, align, add/sub, normalise, then hand the result out.
module fp_addsub_sequencer #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fp_addsub_sequencer_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 2;
  localparam int CW = $clog2(MW + 1);

  localparam logic [EXP_W-1:0] EONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EMAX1 = {{(EXP_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_DONE
  } state_t;

  state_t           state_q;
  logic             zs_q;
  logic             mas_q;
  logic             ovf_q;
  logic             unf_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             in_ready_q;
  logic [MW-1:0]    bm_q;
  logic [MW-1:0]    sm_q;
  logic [EXP_W-1:0] exp_q;
  logic [CW-1:0]    cnt_q;
  logic [W-1:0]     z_q;

  logic             xs;
  logic             ys_eff;
  logic             xle;
  logic             zs_d;
  logic             mas_d;
  logic [W-2:0]     big_d;
  logic [W-2:0]     small_d;
  logic [EXP_W-1:0] be_d;
  logic [EXP_W-1:0] se_d;
  logic [EXP_W:0]   ediff;
  logic [CW-1:0]    d_d;
  logic [MW-1:0]    bm_d;
  logic [MW-1:0]    sm_d;

  assign xs      = bus.x[W-1];
  assign ys_eff  = bus.y[W-1] ^ bus.op_sub;
  assign xle     = bus.x[W-2:0] <= bus.y[W-2:0];
  assign zs_d    = xle ? ys_eff : xs;
  assign mas_d   = xs ^ ys_eff;
  assign big_d   = xle ? bus.y[W-2:0] : bus.x[W-2:0];
  assign small_d = xle ? bus.x[W-2:0] : bus.y[W-2:0];
  assign be_d    = big_d[W-2:MAN_W];
  assign se_d    = small_d[W-2:MAN_W];

  // Zero-exponent operands are flushed: no hidden bit and no fraction.
  assign bm_d = (be_d != '0) ? {2'b01, big_d[MAN_W-1:0]} : '0;
  assign sm_d = (se_d != '0) ? {2'b01, small_d[MAN_W-1:0]} : '0;

  assign ediff = {1'b0, be_d} - {1'b0, se_d};
  assign d_d   = (ediff >= (EXP_W+1)'(MW)) ? CW'(MW)
                                            : ediff[CW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      zs_q        <= 1'b0;
      mas_q       <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      bm_q        <= '0;
      sm_q        <= '0;
      exp_q       <= '0;
      cnt_q       <= '0;
      z_q         <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            zs_q       <= zs_d;
            mas_q      <= mas_d;
            bm_q       <= bm_d;
            sm_q       <= sm_d;
            exp_q      <= be_d;
            cnt_q      <= d_d;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b0;
            state_q    <= (d_d != '0) ? S_ALIGN : S_ADD;
          end
        end
        S_ALIGN: begin
          sm_q  <= sm_q >> 1;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1))
            state_q <= S_ADD;
        end
        S_ADD: begin
          bm_q    <= mas_q ? bm_q - sm_q : bm_q + sm_q;
          state_q <= S_NORM;
        end
        S_NORM: begin
          if (bm_q == '0) begin
            z_q         <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else if (bm_q[MAN_W+1]) begin
            if (exp_q == EMAX1) begin
              z_q   <= {zs_q, EONES, {MAN_W{1'b0}}};
              ovf_q <= 1'b1;
            end else begin
              z_q <= {zs_q, exp_q + 1'b1, bm_q[MAN_W:1]};
            end
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else if (bm_q[MAN_W]) begin
            z_q         <= {zs_q, exp_q, bm_q[MAN_W-1:0]};
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else if (exp_q <= EXP_W'(1)) begin
            // Exponent would hit zero before the hidden bit appears.
            z_q         <= {zs_q, {(W-1){1'b0}}};
            unf_q       <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            bm_q  <= bm_q << 1;
            exp_q <= exp_q - 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.z         = z_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.busy      = busy_q;

endmodule
